// File: rtl/regfile_wr_arb.sv
// Two-requester write-port arbiter for a 32x32 register file with a single write port.
// Optional build macro WR_ARB_RR_EN selects round-robin tie-breaking; without it requester 0 has fixed priority.
module regfile_wr_arb #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic          Clk,
  input  logic          Clrn,
  input  logic          Stall,
  input  logic          Req0,
  input  logic [AW-1:0] Addr0,
  input  logic [DW-1:0] Data0,
  output logic          Gnt0,
  input  logic          Req1,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] Data1,
  output logic          Gnt1,
  output logic          We,
  output logic [AW-1:0] Wn,
  output logic [DW-1:0] D,
  output logic          Last
);

  logic          we_q,   we_d;
  logic [AW-1:0] wn_q,   wn_d;
  logic [DW-1:0] d_q,    d_d;
  logic          last_q, last_d;
  logic          tie_pick1_c;

`ifdef WR_ARB_RR_EN
  // On a tie the requester that did not win most recently goes next.
  assign tie_pick1_c = ~last_q;
`else
  assign tie_pick1_c = 1'b0;
`endif

  // Combinational grant; suppressed while in reset or stalled.
  always_comb begin
    Gnt0 = 1'b0;
    Gnt1 = 1'b0;
    if (Clrn && !Stall) begin
      if (Req0 && Req1) begin
        Gnt1 = tie_pick1_c;
        Gnt0 = ~tie_pick1_c;
      end else begin
        Gnt0 = Req0;
        Gnt1 = Req1;
      end
    end
  end

  // Writes to register 0 are consumed but never issued to the register file.
  always_comb begin
    we_d   = 1'b0;
    wn_d   = wn_q;
    d_d    = d_q;
    last_d = last_q;
    if (Gnt0) begin
      we_d   = |Addr0;
      wn_d   = Addr0;
      d_d    = Data0;
      last_d = 1'b0;
    end else if (Gnt1) begin
      we_d   = |Addr1;
      wn_d   = Addr1;
      d_d    = Data1;
      last_d = 1'b1;
    end
  end

  // Last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      we_q   <= 1'b0;
      wn_q   <= AW'(0);
      d_q    <= DW'(0);
      last_q <= 1'b1;
    end else begin
      we_q   <= we_d;
      wn_q   <= wn_d;
      d_q    <= d_d;
      last_q <= last_d;
    end
  end

  assign We   = we_q;
  assign Wn   = wn_q;
  assign D    = d_q;
  assign Last = last_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed self-checking bench for regfile_wr_arb; expectations follow WR_ARB_RR_EN when defined.
module tb_regfile_wr_arb;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
`ifdef WR_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Clrn;
  logic          Stall;
  logic          Req0, Req1;
  logic [AW-1:0] Addr0, Addr1;
  logic [DW-1:0] Data0, Data1;
  logic          Gnt0, Gnt1;
  logic          We;
  logic [AW-1:0] Wn;
  logic [DW-1:0] D;
  logic          Last;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wr_arb #(.AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Clrn(Clrn), .Stall(Stall),
    .Req0(Req0), .Addr0(Addr0), .Data0(Data0), .Gnt0(Gnt0),
    .Req1(Req1), .Addr1(Addr1), .Data1(Data1), .Gnt1(Gnt1),
    .We(We), .Wn(Wn), .D(D), .Last(Last)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_gnt(input string tag, input logic g0, input logic g1);
    check({tag, "_gnt0"}, 32'(Gnt0), 32'(g0));
    check({tag, "_gnt1"}, 32'(Gnt1), 32'(g1));
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [AW-1:0] wn,
                          input logic [DW-1:0] d, input logic last);
    check({tag, "_we"},   32'(We),   32'(we));
    check({tag, "_wn"},   32'(Wn),   32'(wn));
    check({tag, "_d"},    32'(D),    32'(d));
    check({tag, "_last"}, 32'(Last), 32'(last));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_w;
    Clrn  = 1'b0;
    Stall = 1'b0;
    Req0  = 1'b1; Addr0 = 5'd3; Data0 = 32'hAAAAAAAA;
    Req1  = 1'b1; Addr1 = 5'd4; Data1 = 32'h55555555;

    // Reset held with both requesting
    for (int i = 0; i < 2; i++) begin
      tick();
      check_gnt("rst", 1'b0, 1'b0);
      check_wr("rst", 1'b0, 5'd0, 32'h0, 1'b1);
    end

    // Release reset; contention for 4 cycles
    Clrn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_w = RR ? 1'(i % 2) : 1'b0;
      #1;
      check_gnt("cont", ~exp_w, exp_w);
      tick();
      check_wr("cont", 1'b1, exp_w ? 5'd4 : 5'd3,
               exp_w ? 32'h55555555 : 32'hAAAAAAAA, exp_w);
    end
    Req0 = 1'b0; Req1 = 1'b0;
    #1;
    check_gnt("idle", 1'b0, 1'b0);
    tick();
    check_wr("idle", 1'b0, RR ? 5'd4 : 5'd3,
             RR ? 32'h55555555 : 32'hAAAAAAAA, RR);

    // Single requester 0
    Req0 = 1'b1; Addr0 = 5'd5; Data0 = 32'h0F0F0F0F;
    #1;
    check_gnt("single", 1'b1, 1'b0);
    tick();
    Req0 = 1'b0;
    check_wr("single", 1'b1, 5'd5, 32'h0F0F0F0F, 1'b0);
    tick();
    check_wr("single_after", 1'b0, 5'd5, 32'h0F0F0F0F, 1'b0);

    // Write to register 0 is granted but not issued
    Req1 = 1'b1; Addr1 = 5'd0; Data1 = 32'hFFFFFFFF;
    #1;
    check_gnt("zero", 1'b0, 1'b1);
    tick();
    Req1 = 1'b0;
    check_wr("zero", 1'b0, 5'd0, 32'hFFFFFFFF, 1'b1);

    // Stall blocks requester 0 for 2 cycles
    Stall = 1'b1;
    Req0 = 1'b1; Addr0 = 5'd9; Data0 = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_gnt("stall", 1'b0, 1'b0);
      tick();
      check_wr("stall", 1'b0, 5'd0, 32'hFFFFFFFF, 1'b1);
    end
    Stall = 1'b0;
    #1;
    check_gnt("unstall", 1'b1, 1'b0);
    tick();
    Req0 = 1'b0;
    check_wr("unstall", 1'b1, 5'd9, 32'h12345678, 1'b0);

    // Tie with Last=0: round-robin picks 1, fixed priority picks 0
    Req0 = 1'b1; Addr0 = 5'd6; Data0 = 32'h00000006;
    Req1 = 1'b1; Addr1 = 5'd6; Data1 = 32'h00000016;
    #1;
    check_gnt("tie_last0", ~RR, RR);
    tick();
    Req0 = 1'b0; Req1 = 1'b0;
    check_wr("tie_last0", 1'b1, 5'd6, RR ? 32'h00000016 : 32'h00000006, RR);
    tick();

    // Reset asserted half a cycle after a grant edge
    Req0 = 1'b1; Addr0 = 5'd7; Data0 = 32'hDEADBEEF;
    #1;
    check_gnt("mid", 1'b1, 1'b0);
    tick();
    check_wr("mid_pre", 1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
    @(negedge Clk);
    Clrn = 1'b0;
    #1;
    check_gnt("mid_rst", 1'b0, 1'b0);
    check_wr("mid_rst", 1'b0, 5'd0, 32'h0, 1'b1);
    Req0 = 1'b0;
    tick();
    Clrn = 1'b1;
    tick();
    check_wr("post_rst", 1'b0, 5'd0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
